// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings and control bundle for the RV32I main-control decoder.
// Holds opcode constants, imm_src/result_src/alu_op encodings, the ctrl_t
// bundle and its all-zero bubble constant.
package riscv_ctrl_pkg;

  // Opcodes, instruction bits [6:0]
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Immediate format
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Write-back source
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       a_src_pc;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // A bubble has every control bit cleared, so it writes nothing anywhere.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational opcode decode into the ctrl_t bundle plus a legal flag.
// Latency: zero (combinational). No flow control; it decodes whatever op it sees.
// Ports: i_op opcode in; o_ctrl decoded bundle; o_legal opcode is recognised.
// FULL_ISA=0 restricts decode to load/store/R-type/branch; all else is illegal.
module ctrl_decode_comb
  import riscv_ctrl_pkg::*;
#(
  parameter int FULL_ISA = 1
) (
  input  logic [6:0] i_op,
  output ctrl_t      o_ctrl,
  output logic       o_legal
);

  localparam bit FULL = (FULL_ISA != 0);

  always_comb begin
    o_ctrl  = CTRL_BUBBLE;
    o_legal = 1'b0;
    case (i_op)
      OP_LOAD: begin
        o_legal           = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.imm_src    = IMM_I;
        o_ctrl.result_src = RES_MEM;
        o_ctrl.alu_op     = ALU_ADD;
      end
      OP_STORE: begin
        o_legal          = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_S;
        o_ctrl.alu_op    = ALU_ADD;
      end
      OP_RTYPE: begin
        o_legal          = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      OP_BRANCH: begin
        o_legal        = 1'b1;
        o_ctrl.branch  = 1'b1;
        o_ctrl.imm_src = IMM_B;
        o_ctrl.alu_op  = ALU_SUB;
      end
      OP_IALU: if (FULL) begin
        o_legal          = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_I;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      OP_JAL: if (FULL) begin
        o_legal           = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.jump       = 1'b1;
        o_ctrl.imm_src    = IMM_J;
        o_ctrl.result_src = RES_PC4;
      end
      // JALR is distinguished from JAL downstream by jump=1 with alu_src=1.
      OP_JALR: if (FULL) begin
        o_legal           = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.jump       = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.imm_src    = IMM_I;
        o_ctrl.result_src = RES_PC4;
      end
      OP_LUI: if (FULL) begin
        o_legal           = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.imm_src    = IMM_U;
        o_ctrl.result_src = RES_IMM;
      end
      OP_AUIPC: if (FULL) begin
        o_legal          = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.a_src_pc  = 1'b1;
        o_ctrl.imm_src   = IMM_U;
      end
      default: begin
        o_ctrl  = CTRL_BUBBLE;
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered main-control decoder driving the ID/EX control register.
// Latency: one cycle from op/in_valid to outputs; no combinational input->output path.
// Backpressure: stall holds every registered output; flush (wins over stall) loads a bubble.
// Ports: clk, rst (sync, active-high); in_valid/op from ID; stall/flush hazard controls;
//   out_valid plus the control bundle to EX; illegal/ill_count for undecoded opcodes.
// Optional feature: define ILLEGAL_TRAP_EN to make illegal and ill_count live;
//   otherwise both are tied to 0 and illegal opcodes are simply captured as bubbles.
module ctrl_decode_pipe
  import riscv_ctrl_pkg::*;
#(
  parameter int FULL_ISA  = 1,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [6:0]           op,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 out_valid,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic                 a_src_pc,
  output logic [2:0]           imm_src,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_op,
  output logic                 branch,
  output logic                 jump,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  ctrl_t w_dec;
  logic  w_legal;
  logic  w_ill_cap;   // a real instruction with an undecoded opcode

  ctrl_t r_ctrl;
  logic  r_valid;

  ctrl_decode_comb #(
    .FULL_ISA (FULL_ISA)
  ) u_dec (
    .i_op    (op),
    .o_ctrl  (w_dec),
    .o_legal (w_legal)
  );

  assign w_ill_cap = in_valid & ~w_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl  <= CTRL_BUBBLE;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_ctrl  <= CTRL_BUBBLE;
      r_valid <= 1'b0;
    end else if (!stall) begin
      if (in_valid && w_legal) begin
        r_ctrl  <= w_dec;
        r_valid <= 1'b1;
      end else begin
        r_ctrl  <= CTRL_BUBBLE;
        r_valid <= 1'b0;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic                 r_illegal;
  logic [ILL_CNT_W-1:0] r_ill_count;

  // Counter advances only on an actual capture, so an illegal op sitting
  // in ID across a stall is counted once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal   <= 1'b0;
      r_ill_count <= '0;
    end else if (flush) begin
      r_illegal <= 1'b0;
    end else if (!stall) begin
      r_illegal <= w_ill_cap;
      if (w_ill_cap && (r_ill_count != {ILL_CNT_W{1'b1}})) begin
        r_ill_count <= r_ill_count + ILL_CNT_W'(1);
      end
    end
  end

  assign illegal   = r_illegal;
  assign ill_count = r_ill_count;
`else
  logic w_ill_unused;
  assign w_ill_unused = w_ill_cap;
  assign illegal      = 1'b0;
  assign ill_count    = '0;
`endif

  assign out_valid  = r_valid;
  assign reg_write  = r_ctrl.reg_write;
  assign mem_write  = r_ctrl.mem_write;
  assign alu_src    = r_ctrl.alu_src;
  assign a_src_pc   = r_ctrl.a_src_pc;
  assign imm_src    = r_ctrl.imm_src;
  assign result_src = r_ctrl.result_src;
  assign alu_op     = r_ctrl.alu_op;
  assign branch     = r_ctrl.branch;
  assign jump       = r_ctrl.jump;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed self-checking bench for ctrl_decode_pipe.
// Two instances share stimulus: F (FULL_ISA=1, ILL_CNT_W=2) and B (FULL_ISA=0, ILL_CNT_W=8).
// Bundle vectors are {out_valid, reg_write, mem_write, alu_src, a_src_pc,
//   imm_src[2:0], result_src[1:0], alu_op[1:0], branch, jump}.
module tb_ctrl_decode_pipe;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Hand-written expected bundles
  localparam logic [14:0] E_BUB   = 15'b0_0_0_0_0_000_00_00_0_0;
  localparam logic [14:0] E_LOAD  = 15'b1_1_0_1_0_000_01_00_0_0;
  localparam logic [14:0] E_STORE = 15'b1_0_1_1_0_001_00_00_0_0;
  localparam logic [14:0] E_RTYPE = 15'b1_1_0_0_0_000_00_10_0_0;
  localparam logic [14:0] E_BR    = 15'b1_0_0_0_0_010_00_01_1_0;
  localparam logic [14:0] E_IALU  = 15'b1_1_0_1_0_000_00_10_0_0;
  localparam logic [14:0] E_JAL   = 15'b1_1_0_0_0_011_10_00_0_1;
  localparam logic [14:0] E_JALR  = 15'b1_1_0_1_0_000_10_00_0_1;
  localparam logic [14:0] E_LUI   = 15'b1_1_0_0_0_100_11_00_0_0;
  localparam logic [14:0] E_AUIPC = 15'b1_1_0_1_1_100_00_00_0_0;

  localparam logic [6:0] O_LOAD  = 7'b0000011;
  localparam logic [6:0] O_STORE = 7'b0100011;
  localparam logic [6:0] O_RTYPE = 7'b0110011;
  localparam logic [6:0] O_BR    = 7'b1100011;
  localparam logic [6:0] O_IALU  = 7'b0010011;
  localparam logic [6:0] O_JAL   = 7'b1101111;
  localparam logic [6:0] O_JALR  = 7'b1100111;
  localparam logic [6:0] O_LUI   = 7'b0110111;
  localparam logic [6:0] O_AUIPC = 7'b0010111;
  localparam logic [6:0] O_BAD   = 7'b1111111;

  logic clk = 1'b0;
  logic rst, in_valid, stall, flush;
  logic [6:0] op;

  logic       f_vld, f_rw, f_mw, f_as, f_ap, f_br, f_j, f_ill;
  logic [2:0] f_imm;
  logic [1:0] f_res, f_aop, f_cnt;
  logic       b_vld, b_rw, b_mw, b_as, b_ap, b_br, b_j, b_ill;
  logic [2:0] b_imm;
  logic [1:0] b_res, b_aop;
  logic [7:0] b_cnt;

  int checks = 0;
  int errors = 0;
  int exp_f_cnt = 0;
  int exp_b_cnt = 0;

  always #5 clk = ~clk;

  ctrl_decode_pipe #(.FULL_ISA(1), .ILL_CNT_W(2)) dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .stall(stall), .flush(flush),
    .out_valid(f_vld), .reg_write(f_rw), .mem_write(f_mw), .alu_src(f_as), .a_src_pc(f_ap),
    .imm_src(f_imm), .result_src(f_res), .alu_op(f_aop), .branch(f_br), .jump(f_j),
    .illegal(f_ill), .ill_count(f_cnt)
  );

  ctrl_decode_pipe #(.FULL_ISA(0), .ILL_CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .stall(stall), .flush(flush),
    .out_valid(b_vld), .reg_write(b_rw), .mem_write(b_mw), .alu_src(b_as), .a_src_pc(b_ap),
    .imm_src(b_imm), .result_src(b_res), .alu_op(b_aop), .branch(b_br), .jump(b_j),
    .illegal(b_ill), .ill_count(b_cnt)
  );

  wire [14:0] f_bun = {f_vld, f_rw, f_mw, f_as, f_ap, f_imm, f_res, f_aop, f_br, f_j};
  wire [14:0] b_bun = {b_vld, b_rw, b_mw, b_as, b_ap, b_imm, b_res, b_aop, b_br, b_j};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare one instance's bundle, illegal flag and counter.
  task automatic chk_f(input string tag, input logic [14:0] eb, input logic ei);
    chk({"F ", tag, " bundle"}, 32'(f_bun), 32'(eb));
    chk({"F ", tag, " illegal"}, 32'(f_ill), 32'(ei & TRAP));
    chk({"F ", tag, " count"}, 32'(f_cnt), TRAP ? 32'(exp_f_cnt) : 32'd0);
  endtask

  task automatic chk_b(input string tag, input logic [14:0] eb, input logic ei);
    chk({"B ", tag, " bundle"}, 32'(b_bun), 32'(eb));
    chk({"B ", tag, " illegal"}, 32'(b_ill), 32'(ei & TRAP));
    chk({"B ", tag, " count"}, 32'(b_cnt), TRAP ? 32'(exp_b_cnt) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = O_LOAD; stall = 1'b0; flush = 1'b0;
    tick();
    chk_f("reset", E_BUB, 1'b0);
    chk_b("reset", E_BUB, 1'b0);

    // Load: one-cycle latency
    rst = 1'b0; in_valid = 1'b1; op = O_LOAD;
    tick();
    chk_f("load", E_LOAD, 1'b0);
    chk_b("load", E_LOAD, 1'b0);

    // JAL: decoded by F, illegal on the reduced decoder
    op = O_JAL; tick(); exp_b_cnt = 1;
    chk_f("jal", E_JAL, 1'b0);
    chk_b("jal", E_BUB, 1'b1);

    op = O_STORE; tick();
    chk_f("store", E_STORE, 1'b0);
    chk_b("store", E_STORE, 1'b0);
    op = O_BR; tick();
    chk_f("branch", E_BR, 1'b0);
    chk_b("branch", E_BR, 1'b0);
    op = O_IALU; tick(); exp_b_cnt = 2;
    chk_f("ialu", E_IALU, 1'b0);
    chk_b("ialu", E_BUB, 1'b1);
    op = O_JALR; tick(); exp_b_cnt = 3;
    chk_f("jalr", E_JALR, 1'b0);
    chk_b("jalr", E_BUB, 1'b1);
    op = O_LUI; tick(); exp_b_cnt = 4;
    chk_f("lui", E_LUI, 1'b0);
    chk_b("lui", E_BUB, 1'b1);
    op = O_AUIPC; tick(); exp_b_cnt = 5;
    chk_f("auipc", E_AUIPC, 1'b0);
    chk_b("auipc", E_BUB, 1'b1);

    // in_valid low: bubble, never counted even for an undecoded op
    in_valid = 1'b0; op = O_BAD; tick();
    chk_f("invalid", E_BUB, 1'b0);
    chk_b("invalid", E_BUB, 1'b0);

    // R-type then 3-cycle stall while op changes to store
    in_valid = 1'b1; op = O_RTYPE; tick();
    chk_f("rtype", E_RTYPE, 1'b0);
    stall = 1'b1; op = O_STORE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_f("stall hold", E_RTYPE, 1'b0);
      chk_b("stall hold", E_RTYPE, 1'b0);
    end

    // stall and flush together: flush wins
    flush = 1'b1; tick();
    chk_f("stall+flush", E_BUB, 1'b0);
    chk_b("stall+flush", E_BUB, 1'b0);

    // Five illegal captures: F saturates at 3, B keeps counting
    stall = 1'b0; flush = 1'b0; op = O_BAD;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_f_cnt = (i > 3) ? 3 : i;
      exp_b_cnt++;
      chk_f("sat", E_BUB, 1'b1);
      chk_b("sat", E_BUB, 1'b1);
    end

    // flush clears illegal but keeps the count
    flush = 1'b1; tick();
    chk_f("flush ill", E_BUB, 1'b0);
    chk_b("flush ill", E_BUB, 1'b0);

    // Reset asserted mid-stall/flush clears everything, counters included
    stall = 1'b1; rst = 1'b1; tick();
    exp_f_cnt = 0; exp_b_cnt = 0;
    chk_f("rst mid-stall", E_BUB, 1'b0);
    chk_b("rst mid-stall", E_BUB, 1'b0);

    // Illegal captured once, then held under stall for 4 cycles
    rst = 1'b0; flush = 1'b0; stall = 1'b0; op = O_BAD; tick();
    exp_f_cnt = 1; exp_b_cnt = 1;
    chk_f("ill capture", E_BUB, 1'b1);
    chk_b("ill capture", E_BUB, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_f("ill stall", E_BUB, 1'b1);
      chk_b("ill stall", E_BUB, 1'b1);
    end
    stall = 1'b0; op = O_LOAD; tick();
    chk_f("ill release", E_LOAD, 1'b0);
    chk_b("ill release", E_LOAD, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Registered main-control decoder for the RV32I pipeline. It decodes the opcode in ID and drives the control bundle into the ID/EX pipeline register, with stall hold, flush-to-bubble and optional illegal-opcode detection. It extends the four-opcode decoder (load, store, R-type, branch) to a selectable subset of RV32I. It widens immediate and result selection for jumps and upper-immediate instructions.

## Interface

Parameters:
- FULL_ISA, default 1. When 1, decode all nine opcodes listed under Operation. When 0, decode only load, store, R-type and branch.
- ILL_CNT_W, default 8. Width of the illegal-opcode counter.

Ports:
- clk, input, 1. Sole clock; all state updates on its rising edge.
- rst, input, 1. Synchronous, active-high reset.
- in_valid, input, 1. The ID-stage instruction is real; when 0 it is a bubble.
- op, input, 7. Instruction opcode field, bits [6:0].
- stall, input, 1. Hold the ID/EX control register.
- flush, input, 1. Load a bubble into the ID/EX control register.
- out_valid, output, 1. The registered bundle is a real instruction.
- reg_write, output, 1. Register-file write enable.
- mem_write, output, 1. Data-memory write enable.
- alu_src, output, 1. ALU operand B: 0 selects rs2, 1 selects the immediate.
- a_src_pc, output, 1. ALU operand A: 0 selects rs1, 1 selects PC.
- imm_src, output, 3. Immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- result_src, output, 2. Write-back source: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
- alu_op, output, 2. ALU operation class: 00 add, 01 subtract/compare, 10 decoded from funct.
- branch, output, 1. Conditional branch.
- jump, output, 1. Unconditional jump. JALR is identified by jump=1 with alu_src=1.
- illegal, output, 1. The registered instruction had an undecoded opcode.
- ill_count, output, ILL_CNT_W. Count of illegal opcodes captured.

## Operation

Opcode decode. Any signal not listed for an opcode is 0.
- 0000011 load: reg_write=1, alu_src=1, imm_src=000, result_src=01, alu_op=00.
- 0100011 store: mem_write=1, alu_src=1, imm_src=001, alu_op=00.
- 0110011 R-type: reg_write=1, alu_op=10.
- 1100011 branch: branch=1, imm_src=010, alu_op=01.
- The following opcodes are decoded only when FULL_ISA=1:
  - 0010011 I-ALU: reg_write=1, alu_src=1, imm_src=000, alu_op=10.
  - 1101111 JAL: reg_write=1, jump=1, imm_src=011, result_src=10.
  - 1100111 JALR: reg_write=1, jump=1, alu_src=1, imm_src=000, result_src=10.
  - 0110111 LUI: reg_write=1, imm_src=100, result_src=11.
  - 0010111 AUIPC: reg_write=1, alu_src=1, a_src_pc=1, imm_src=100.
- Any other opcode is illegal. Its control is the all-zero bubble.

Register update, in priority order, at each rising clk edge:
1. rst: all outputs, including ill_count, become 0.
2. flush: bundle becomes the bubble; out_valid=0; illegal=0.
3. stall: all registered outputs hold their values.
4. Otherwise capture:
   - If in_valid=1, load the decoded bundle and set out_valid=1.
   - If in_valid=0, load the bubble and set out_valid=0.
   - An illegal in_valid instruction loads the bubble with out_valid=0 and illegal=1.
- ill_count increments by 1 only on a capture (case 4) of an illegal in_valid instruction. It saturates at 2^ILL_CNT_W-1.

## Timing

- Latency is one cycle from op/in_valid to the registered outputs.
- There is no combinational path from the inputs to the outputs.
- flush and stall asserted together: flush wins.
- A stall held for N cycles leaves the outputs constant for N cycles. An illegal instruction under stall is counted once, on the cycle it is captured.
- rst asserted mid-stall or mid-flush clears everything on that edge. Normal operation resumes on the first edge after rst deasserts.
- ill_count at saturation stays at its maximum value. A further illegal capture still pulses illegal.

## Configuration

- ILLEGAL_TRAP_EN defined: the illegal output and ill_count are live, as described above.
- ILLEGAL_TRAP_EN undefined:
  - illegal and ill_count are tied to 0, and the counter logic is removed.
  - Illegal opcodes are still loaded as bubbles with out_valid=0.

## Structure

- Shared package riscv_ctrl_pkg holds:
  - opcode localparams;
  - imm_src, result_src and alu_op encoding constants;
  - the control bundle struct ctrl_t, including its bubble constant.
- Sub-module ctrl_decode_comb performs the purely combinational decode of op under FULL_ISA. It returns ctrl_t and a legal flag.
- The top module holds the register, the priority logic and the counter.

## Test plan

- Reset, then apply op=0000011 with in_valid=1 → next cycle: reg_write=1, alu_src=1, result_src=01, out_valid=1.
- FULL_ISA=0, op=1101111 with in_valid=1 → bubble, out_valid=0, illegal=1, ill_count=1. With FULL_ISA=1 the same op gives jump=1, imm_src=011, result_src=10.
- Load the R-type op, then assert stall for 3 cycles while op changes to store → outputs hold the R-type bundle for all 3 cycles.
- stall=1 and flush=1 together → bubble with out_valid=0.
- ILL_CNT_W=2, five consecutive illegal captures → ill_count reads 1, 2, 3, 3, 3, and illegal pulses every cycle.
- Illegal op held under stall for 4 cycles, then released → ill_count increments exactly once. Build with ILLEGAL_TRAP_EN undefined → illegal and ill_count are 0 throughout.
